// File: rtl/i2c_slave_responder_if.sv
// Register-access and bus-level signals between the I2C target and its user/bus side.
// Signal names follow the legacy port list so existing hookups carry over unchanged.
interface i2c_slave_responder_if #(
  parameter int unsigned PTR_W = 8
) ();
  logic             scl_i;
  logic             sda_i;
  logic             sda_oe;
  logic             busy;
  logic             wr_valid;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             rd_req;
  logic [PTR_W-1:0] rd_addr;
  logic [7:0]       rd_data;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_oe, busy, wr_valid, wr_addr, wr_data, rd_req, rd_addr
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_oe, busy, wr_valid, wr_addr, wr_data, rd_req, rd_addr
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: START/STOP decode, 7-bit address match, register pointer with auto-increment,
// byte-wide write strobes and read requests. Oversamples scl/sda on clk, never stretches scl.
module i2c_slave_responder #(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned PTR_W    = 8,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_slave_responder_if.slave bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] IGNORE   = 4'd3;
  localparam logic [3:0] PTR      = 4'd4;
  localparam logic [3:0] WDATA    = 4'd5;
  localparam logic [3:0] DACK     = 4'd6;
  localparam logic [3:0] RDATA    = 4'd7;
  localparam logic [3:0] RACK     = 4'd8;

  logic [SYNC_STG-1:0] scl_sync_q, sda_sync_q;
  logic                scl_prev_q, sda_prev_q;
  logic [3:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          sr_q, sr_d;
  logic                rw_q, rw_d;
  logic                nack_q, nack_d;
  logic                rd_pend_q, rd_pend_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                rd_req_q, rd_req_d;
  logic [PTR_W-1:0]    rd_addr_q, rd_addr_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in;

  assign scl_s    = scl_sync_q[SYNC_STG-1];
  assign sda_s    = sda_sync_q[SYNC_STG-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in  = {sr_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rw_d       = rw_q;
    nack_d     = nack_q;
    rd_pend_d  = 1'b0;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;

    if (start_c) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_c) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, IGNORE: ;
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7 && state_q == PTR) ptr_d = PTR_W'(byte_in);
            if (cnt_q == 4'd7 && state_q == WDATA) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in;
              ptr_d      = ptr_q + 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              rw_d = sr_q[0];
              if (sr_q[7:1] == SLV_ADDR) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              state_d  = DACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        ADDR_ACK, DACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d   = RDATA;
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
              rd_pend_d = 1'b1;
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          // rd_data arrives one clk after rd_req; first bit goes out while scl is still low
          if (rd_pend_q) begin
            sr_d     = bus.rd_data;
            sda_oe_d = ~bus.rd_data[7];
            cnt_d    = '0;
          end else if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              state_d  = RACK;
            end else begin
              sr_d     = {sr_q[6:0], 1'b0};
              sda_oe_d = ~sr_q[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            nack_d = sda_s;
          end else if (scl_fall) begin
            if (!nack_q) begin
              state_d   = RDATA;
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
              rd_pend_d = 1'b1;
              cnt_d     = '0;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STG-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STG-2:0], bus.sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      rd_pend_q  <= rd_pend_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_req   = rd_req_q;
  assign bus.rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-bangs an I2C master against the responder and checks ACKs, strobes,
// read data, pointer behaviour and async reset.
module tb_i2c_slave_responder;
  localparam int H = 8;
  localparam int Q = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  always #5 clk = ~clk;

  i2c_slave_responder_if #(.PTR_W(8)) bus ();

  assign bus.scl_i   = m_scl;
  assign bus.sda_i   = m_sda & ~bus.sda_oe;
  assign bus.rd_data = bus.rd_addr ^ 8'hFF;

  i2c_slave_responder #(.SLV_ADDR(7'h50), .PTR_W(8), .SYNC_STG(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [7:0] rd_a[$];
  int   oe_hi_viol = 0;
  int   both_viol  = 0;
  logic oe_seen    = 1'b0;
  logic oe_prev    = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.wr_valid === 1'b1) begin
      wr_a.push_back(bus.wr_addr);
      wr_d.push_back(bus.wr_data);
    end
    if (bus.rd_req === 1'b1) rd_a.push_back(bus.rd_addr);
    if (bus.wr_valid === 1'b1 && bus.rd_req === 1'b1) both_viol++;
    if (bus.sda_oe !== oe_prev && m_scl) oe_hi_viol++;
    oe_prev = bus.sda_oe;
    if (bus.sda_oe === 1'b1) oe_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; clks(Q);
    m_scl = 1'b1; clks(H);
    m_sda = 1'b0; clks(H);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; clks(Q);
    m_scl = 1'b1; clks(H);
    m_sda = 1'b1; clks(H);
  endtask

  task automatic wbit(input logic b);
    m_sda = b;    clks(Q);
    m_scl = 1'b1; clks(H);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; clks(Q);
    m_scl = 1'b1; clks(H / 2);
    b = m_sda & ~bus.sda_oe;
    clks(H / 2);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(input logic ackbit, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ackbit);
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] addr_byte;

    rst = 1'b1;
    clks(4);
    chk("reset_sda_oe", bus.sda_oe, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_wr_valid", bus.wr_valid, 0);
    chk("reset_rd_req", bus.rd_req, 0);
    rst = 1'b0;
    clks(4);

    // 1: pointer 03, two data bytes, then read back pointer value 5
    clear_log();
    i2c_start();
    wbyte(8'hA0, ack); chk("t1_addr_ack", ack, 0);
    wbyte(8'h03, ack); chk("t1_ptr_ack", ack, 0);
    wbyte(8'hA5, ack); chk("t1_d0_ack", ack, 0);
    wbyte(8'h5A, ack); chk("t1_d1_ack", ack, 0);
    chk("t1_busy_active", bus.busy, 1);
    i2c_stop();
    chk("t1_busy_after_stop", bus.busy, 0);
    chk("t1_wr_count", wr_a.size(), 2);
    chk("t1_wr0_addr", wr_a[0], 8'h03);
    chk("t1_wr0_data", wr_d[0], 8'hA5);
    chk("t1_wr1_addr", wr_a[1], 8'h04);
    chk("t1_wr1_data", wr_d[1], 8'h5A);
    clear_log();
    i2c_start();
    wbyte(8'hA1, ack); chk("t1_rd_addr_ack", ack, 0);
    rbyte(1'b1, d);
    i2c_stop();
    chk("t1_ptr_readback", d, 8'hFA);
    chk("t1_rd_addr", rd_a[0], 8'h05);

    // 2: foreign address is ignored, then own address ACKed again
    clear_log();
    oe_seen = 1'b0;
    i2c_start();
    wbyte(8'hA2, ack); chk("t2_foreign_nack", ack, 1);
    chk("t2_busy", bus.busy, 0);
    wbyte(8'h77, ack); chk("t2_data_nack", ack, 1);
    i2c_stop();
    chk("t2_oe_never", oe_seen, 0);
    chk("t2_no_wr", wr_a.size(), 0);
    chk("t2_no_rd", rd_a.size(), 0);
    i2c_start();
    wbyte(8'hA0, ack); chk("t2_own_ack", ack, 0);
    i2c_stop();

    // 3: set pointer 10, repeated start, read two bytes (ACK then NACK)
    clear_log();
    i2c_start();
    wbyte(8'hA0, ack); chk("t3_addr_ack", ack, 0);
    wbyte(8'h10, ack); chk("t3_ptr_ack", ack, 0);
    i2c_start();
    wbyte(8'hA1, ack); chk("t3_raddr_ack", ack, 0);
    rbyte(1'b0, d); chk("t3_rd0", d, 8'hEF);
    rbyte(1'b1, d); chk("t3_rd1", d, 8'hEE);
    chk("t3_busy_after_nack", bus.busy, 0);
    i2c_stop();
    chk("t3_rd_count", rd_a.size(), 2);
    chk("t3_rd_addr0", rd_a[0], 8'h10);
    chk("t3_rd_addr1", rd_a[1], 8'h11);
    chk("t3_no_wr", wr_a.size(), 0);

    // 4: pointer wrap from FF to 00
    clear_log();
    i2c_start();
    wbyte(8'hA0, ack);
    wbyte(8'hFF, ack);
    wbyte(8'h11, ack);
    wbyte(8'h22, ack); chk("t4_last_ack", ack, 0);
    i2c_stop();
    chk("t4_wr_count", wr_a.size(), 2);
    chk("t4_wr0_addr", wr_a[0], 8'hFF);
    chk("t4_wr0_data", wr_d[0], 8'h11);
    chk("t4_wr1_addr", wr_a[1], 8'h00);
    chk("t4_wr1_data", wr_d[1], 8'h22);

    // 5: STOP after half a data byte leaves pointer at 40
    clear_log();
    i2c_start();
    wbyte(8'hA0, ack);
    wbyte(8'h40, ack); chk("t5_ptr_ack", ack, 0);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
    i2c_stop();
    chk("t5_busy", bus.busy, 0);
    chk("t5_no_wr", wr_a.size(), 0);
    i2c_start();
    wbyte(8'hA1, ack);
    rbyte(1'b1, d);
    i2c_stop();
    chk("t5_ptr_kept", d, 8'hBF);
    chk("t5_rd_addr", rd_a[0], 8'h40);

    // 6: async reset while the address ACK is being driven
    clear_log();
    i2c_start();
    addr_byte = 8'hA0;
    for (int i = 7; i >= 0; i--) wbit(addr_byte[i]);
    chk("t6_oe_in_ack", bus.sda_oe, 1);
    chk("t6_busy_in_ack", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_oe_async_clear", bus.sda_oe, 0);
    clks(2);
    rst = 1'b0;
    clks(2);
    chk("t6_busy_after_rst", bus.busy, 0);
    i2c_stop();
    i2c_start();
    wbyte(8'hA1, ack); chk("t6_addr_ack", ack, 0);
    rbyte(1'b1, d);
    i2c_stop();
    chk("t6_ptr_zero_data", d, 8'hFF);
    chk("t6_rd_addr", rd_a[0], 8'h00);

    chk("oe_change_while_scl_high", oe_hi_viol, 0);
    chk("wr_rd_same_clk", both_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
